mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported data memory (1024 x 32, word address on bits [11:2], 4-bit byte enable, one-cycle registered read) between two requesters.
  - Instruction-fetch port: read-only, word access.
  - Data port: load/store of byte, half or word.
- Arbitrates between the ports, sequences each access through a small FSM and generates byte enables and write-data replication.
- Aligns and extends load data and flags misaligned accesses.
- Sits between the multicycle control/datapath and the memory instance.

Parameters:
- ADDR_W, 10, memory word-address width; drives mem_addr, taken from req addr[ADDR_W+1:2].
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = fetch port always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetched word; valid while if_ack.
- if_err  out  1  misaligned fetch; valid while if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- d_signed  in  1  sign-extend load result.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  extended load data; valid while d_ack.
- d_err  out  1  misaligned or illegal-size access; valid while d_ack.
- mem_addr  out  ADDR_W  memory word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  memory read data; valid the cycle after mem_read.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset state:
  - FSM in IDLE.
  - All acks, errs, mem_read and mem_write are 0.
  - mem_addr, mem_be, mem_wdata, if_rdata and d_rdata are 0.
  - Round-robin pointer set so the fetch port wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples if_req and d_req.
  - If either is high, latches winner, address, size, we, signed and wdata into issue registers.
  - Next state is ACCESS, or DONE directly if the request is misaligned.
- ACCESS (exactly one cycle):
  - mem_read = ~we, or mem_write = we, driven from the issue registers, with mem_addr, mem_be and mem_wdata.
  - Next state is DONE.
- DONE (exactly one cycle):
  - Winner's ack = 1; the other port's ack = 0.
  - rdata is taken from mem_rdata, aligned and extended. rdata is 0 for stores and errors.
  - Next state is IDLE.
- Latency: aligned access is 3 cycles from req sampled to ack, and 2 cycles for a misaligned access. Throughput is at most one access per 3 cycles.
- Requester handshake: the requester deasserts req in the cycle after ack. If req is still high in the following IDLE, it is treated as a new request.
- Arbitration:
  - Single request: granted.
  - Both requesting: with FIXED_PRIO=0 the port not granted last wins; with FIXED_PRIO=1 fetch wins.
  - The pointer updates only on grant.
- Requests arriving during ACCESS/DONE are ignored until IDLE. Requests are never dropped because req is held.
- Byte enables: byte = 0001 << a[1:0]; half = a[1] ? 1100 : 0011; word = 1111. Fetch is always 1111.
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word passed through.
- Load extract: select the lane by a[1:0] (byte) or a[1] (half), then zero- or sign-extend per d_signed.
- Misaligned cases: half with a[0]=1; word or fetch with a[1:0]≠0; d_size=11.
  - No mem_read or mem_write is issued.
  - err=1 with ack in DONE.
- Address bits [31:ADDR_W+2] are ignored and alias into memory.
- Reset asserted mid-transaction: immediate return to IDLE, strobes and ack drop asynchronously, and the transaction is lost. A write is lost unless the mem_write edge already occurred.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - port index constants PORT_IF/PORT_D.
- Sub-module mem_lane_align (combinational), which provides:
  - BE generation.
  - wdata replication.
  - misalign detect.
  - load extract/extend.
- mem_port_arbiter instantiates mem_lane_align once, on the issue registers.

Test Plan:
- Fetch only, if_addr=0x10, mem[4]=0x12345678 -> mem_read in cycle 1 with mem_addr=4 and mem_be=1111; if_ack with if_rdata=0x12345678 in cycle 2.
- Store byte, d_addr=0x23, d_wdata=0xAB -> mem_write in cycle 1 with mem_addr=8, mem_be=1000, mem_wdata=0xABABABAB; d_ack in cycle 2 with d_err=0.
- Load signed byte from 0x21, memory word 0x0000_80FF at addr 8 -> d_rdata=0xFFFFFF80. Same load with d_signed=0 -> 0x00000080.
- Half load at 0x03 -> no mem_read, d_ack with d_err=1 one cycle after sampling. Word store at 0x06 -> same result, no mem_write.
- if_req and d_req held continuously, FIXED_PRIO=0 -> grants alternate IF, D, IF, D starting with IF after reset; 4 acks in 12 cycles.
- reset asserted during ACCESS of a read -> mem_read and acks drop immediately; after release FSM is IDLE and the held request is re-served with a normal 3-cycle latency.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared encodings for the memory port arbiter: access size
//               codes, FSM state type, requester port indices and the
//               alignment rule used by both the arbiter and the lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Size code 2'b11 has no legal meaning and is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic result;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = addr_lo[0];
      SZ_WORD: result = (addr_lo != 2'b00);
      default: result = 1'b1;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane handling for a 32-bit word memory.
//               Builds byte enables, replicates store data across lanes,
//               flags misaligned accesses and extracts/extends load data.
// Ports       : size       - access size code (mem_pkg SZ_*)
//               addr_lo    - byte offset within the word
//               sign_ext   - sign-extend extracted load data
//               wdata_in   - right-justified store data
//               rdata_raw  - raw word read from memory
//               be         - byte enables
//               wdata_rep  - lane-replicated store data
//               misaligned - access violates alignment or size is illegal
//               rdata_ext  - aligned and extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'd0;
    rdata_ext  = 32'd0;
    byte_lane  = 8'd0;
    half_lane  = 16'd0;
    misaligned = is_misaligned(size, addr_lo);
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata_in[7:0]}};
        byte_lane = rdata_raw[{addr_lo, 3'b000} +: 8];
        rdata_ext = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_in[15:0]}};
        half_lane = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        rdata_ext = {{16{sign_ext & half_lane[15]}}, half_lane};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata_in;
        rdata_ext = rdata_raw;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported 32-bit data memory between an
//               instruction-fetch port and a load/store data port. Each
//               access runs IDLE -> ACCESS -> DONE (misaligned: IDLE -> DONE).
// Ports       : clk, reset               - clock, async active-high reset
//               if_req/if_addr           - fetch request (held until ack)
//               if_ack/if_rdata/if_err   - fetch completion
//               d_req/d_we/d_size/d_signed/d_addr/d_wdata - data request
//               d_ack/d_rdata/d_err      - data completion
//               mem_addr/mem_be/mem_wdata/mem_read/mem_write - memory side
//               mem_rdata                - read data, one cycle after read
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                load_issue;

  logic                iss_port;
  logic                iss_we;
  logic                iss_signed;
  logic [1:0]          iss_size;
  logic [ADDR_W+1:0]   iss_addr;
  logic [31:0]         iss_wdata;

  logic                winner;
  logic                sel_we;
  logic                sel_signed;
  logic [1:0]          sel_size;
  logic [ADDR_W+1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  logic [3:0]          al_be;
  logic [31:0]         al_wdata;
  logic                al_misaligned;
  logic [31:0]         al_rdata;

  // Upper address bits alias into memory and are deliberately dropped.
  logic unused_high_addr;
  assign unused_high_addr = ^{if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  // Grant selection. On a tie in round-robin mode the port that did not
  // win last time is chosen; last_grant resets to PORT_D so fetch wins first.
  always_comb begin
    if (if_req && d_req) begin
      if (FIXED_PRIO)
        winner = PORT_IF;
      else
        winner = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
    end else begin
      winner = d_req ? PORT_D : PORT_IF;
    end
    sel_addr   = (winner == PORT_D) ? d_addr[ADDR_W+1:0] : if_addr[ADDR_W+1:0];
    sel_size   = (winner == PORT_D) ? d_size : SZ_WORD;
    sel_we     = (winner == PORT_D) & d_we;
    sel_signed = (winner == PORT_D) & d_signed;
    sel_wdata  = (winner == PORT_D) ? d_wdata : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_D;
      iss_port   <= PORT_IF;
      iss_we     <= 1'b0;
      iss_signed <= 1'b0;
      iss_size   <= SZ_BYTE;
      iss_addr   <= '0;
      iss_wdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (load_issue) begin
        last_grant <= winner;
        iss_port   <= winner;
        iss_we     <= sel_we;
        iss_signed <= sel_signed;
        iss_size   <= sel_size;
        iss_addr   <= sel_addr;
        iss_wdata  <= sel_wdata;
      end
    end
  end

  mem_lane_align u_align (
    .size       (iss_size),
    .addr_lo    (iss_addr[1:0]),
    .sign_ext   (iss_signed),
    .wdata_in   (iss_wdata),
    .rdata_raw  (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .misaligned (al_misaligned),
    .rdata_ext  (al_rdata)
  );

  // Next-state and outputs. All outputs decode from the state register, so
  // an asynchronous reset drops strobes and acks immediately.
  always_comb begin
    state_nxt  = state;
    load_issue = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'd0;
    if_ack     = 1'b0;
    if_err     = 1'b0;
    if_rdata   = 32'd0;
    d_ack      = 1'b0;
    d_err      = 1'b0;
    d_rdata    = 32'd0;
    case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          load_issue = 1'b1;
          state_nxt  = is_misaligned(sel_size, sel_addr[1:0]) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_read  = ~iss_we;
        mem_write = iss_we;
        mem_addr  = iss_addr[ADDR_W+1:2];
        mem_be    = al_be;
        mem_wdata = al_wdata;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (iss_port == PORT_IF) begin
          if_ack   = 1'b1;
          if_err   = al_misaligned;
          if_rdata = al_misaligned ? 32'd0 : al_rdata;
        end else begin
          d_ack   = 1'b1;
          d_err   = al_misaligned;
          d_rdata = (al_misaligned || iss_we) ? 32'd0 : al_rdata;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
